store_buffer: RTL and testbench

- Posted-write buffer between the datapath's memory stage and dmem.
- Queues sw/sb stores in a small FIFO and drains them to dmem one per cycle, in program order, over dmem's single shared address port.
- Loads read dmem directly. A load stalls the pipeline while any buffered store targets the same word.
- Lets back-to-back stores retire without waiting on the memory port.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/sb_fifo.sv | 77 +++++++
 rtl/store_buffer.sv | 98 +++++++++
 tb/tb_store_buffer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared memory-side definitions: dmem opcodes and the store buffer entry
// layout used by the store buffer and its FIFO.
package mem_pkg;

    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;
    localparam logic [5:0] OP_SB = 6'b101000;

    // Entries carry a full 32-bit address; narrower AW instances zero-extend.
    localparam int AW_MAX = 32;

    typedef struct packed {
        logic [AW_MAX-1:0] addr;
        logic [31:0]       data;
        logic [5:0]        opcode;
    } store_entry_t;

    // True when two byte addresses fall in the same 32-bit word.
    function automatic logic same_word(input logic [AW_MAX-1:0] a,
                                       input logic [AW_MAX-1:0] b);
        return a[AW_MAX-1:2] == b[AW_MAX-1:2];
    endfunction

endpackage

// File: rtl/sb_fifo.sv
// Circular store-entry array for the store buffer. Exposes every entry's
// valid bit and address so the owner can search for word hits in parallel.
module sb_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_push,
    input  store_entry_t                  i_entry,
    input  logic                          i_pop,
    output store_entry_t                  o_head,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [DEPTH-1:0]              o_entry_valid,
    output logic [DEPTH-1:0][AW_MAX-1:0]  o_entry_addr
);

    store_entry_t     r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

    // A push into a full array is legal when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    assign o_head        = r_mem[r_head];
    assign o_entry_valid = r_valid;

    always_comb begin
        o_entry_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_entry_addr[i] = r_mem[i].addr;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_tail] <= i_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_do_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PW'(1);
            end
            if (w_do_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the memory stage and dmem: queues stores,
// drains them in program order over the shared port, and stalls word-hit loads.
module store_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cpu_we,
    input  logic          cpu_re,
    input  logic [5:0]    cpu_opcode,
    input  logic [AW-1:0] cpu_a,
    input  logic [31:0]   cpu_wd,
    output logic [31:0]   cpu_rd,
    output logic          stall,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [31:0]   mem_wd,
    output logic [5:0]    mem_opcode,
    input  logic [31:0]   mem_rd,
    output logic          empty,
    output logic          full
);

    store_entry_t            w_head;
    store_entry_t            w_new_entry;
    logic [DEPTH-1:0]        w_entry_valid;
    logic [DEPTH-1:0][AW_MAX-1:0] w_entry_addr;

    logic w_we;
    logic w_re;
    logic w_match;
    logic w_load_active;
    logic w_drain;
    logic w_bypass;
    logic w_push;

    // Requests are ignored while reset is asserted so nothing reaches dmem.
    assign w_we = cpu_we && reset_n;
    assign w_re = cpu_re && reset_n;

    always_comb begin
        w_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_entry_valid[i] && same_word(w_entry_addr[i], AW_MAX'(cpu_a))) begin
                w_match = 1'b1;
            end
        end
    end

    // Handshake: stall=1 means the request on cpu_* was not taken and must be
    // presented again next cycle; stall=0 means a store was accepted and a
    // load's cpu_rd is valid now. A store coinciding with a load is queued
    // behind the load, which owns the port that cycle.
    always_comb begin
        w_load_active = w_re && !w_match && !full;
        w_drain       = reset_n && !w_load_active && !empty;
        w_bypass      = !w_load_active && empty && w_we;
        stall         = (w_re && (w_match || full)) || (w_we && full && !w_drain);
        w_push        = w_we && !stall && !w_bypass;
    end

    assign w_new_entry = '{addr: AW_MAX'(cpu_a), data: cpu_wd, opcode: cpu_opcode};

    sb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_push        (w_push),
        .i_entry       (w_new_entry),
        .i_pop         (w_drain),
        .o_head        (w_head),
        .o_full        (full),
        .o_empty       (empty),
        .o_entry_valid (w_entry_valid),
        .o_entry_addr  (w_entry_addr)
    );

    always_comb begin
        mem_we     = w_drain || w_bypass;
        mem_a      = cpu_a;
        mem_wd     = '0;
        mem_opcode = cpu_opcode;
        if (w_drain) begin
            mem_a      = w_head.addr[AW-1:0];
            mem_wd     = w_head.data;
            mem_opcode = w_head.opcode;
        end else if (w_bypass) begin
            mem_wd = cpu_wd;
        end
    end

    assign cpu_rd = mem_rd;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a behavioural dmem and a write
// scoreboard that checks every dmem write against program order.
module tb_store_buffer;
  import mem_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        cpu_we;
  logic        cpu_re;
  logic [5:0]  cpu_opcode;
  logic [31:0] cpu_a;
  logic [31:0] cpu_wd;
  logic [31:0] cpu_rd;
  logic        stall;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [5:0]  mem_opcode;
  logic [31:0] mem_rd;
  logic        empty;
  logic        full;

  int checks = 0;
  int failures = 0;

  logic [69:0] exp_q[$];
  logic [31:0] dmem [0:255];

  store_buffer #(.DEPTH(4), .AW(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_we     (cpu_we),
    .cpu_re     (cpu_re),
    .cpu_opcode (cpu_opcode),
    .cpu_a      (cpu_a),
    .cpu_wd     (cpu_wd),
    .cpu_rd     (cpu_rd),
    .stall      (stall),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_opcode (mem_opcode),
    .mem_rd     (mem_rd),
    .empty      (empty),
    .full       (full)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout act=running req=finished");
    $fatal(1, "timeout");
  end

  // dmem model: byte lanes a%4 = 0/1/2/3 -> bits [31:24]/[23:16]/[15:8]/[7:0]
  initial begin
    for (int i = 0; i < 256; i++) dmem[i] = 32'h0;
  end

  assign mem_rd = dmem[mem_a[9:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_opcode == OP_SB) begin
        case (mem_a[1:0])
          2'd0: dmem[mem_a[9:2]][31:24] <= mem_wd[7:0];
          2'd1: dmem[mem_a[9:2]][23:16] <= mem_wd[7:0];
          2'd2: dmem[mem_a[9:2]][15:8]  <= mem_wd[7:0];
          default: dmem[mem_a[9:2]][7:0] <= mem_wd[7:0];
        endcase
      end else begin
        dmem[mem_a[9:2]] <= mem_wd;
      end
    end
  end

  // scoreboard monitor: every dmem write must be the oldest expected store
  always @(negedge clk) begin
    logic [69:0] e;
    if (reset_n && mem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write act=%h/%h/%b req=no_write", mem_a, mem_wd, mem_opcode);
      end else begin
        e = exp_q.pop_front();
        if ({mem_a, mem_wd, mem_opcode} !== e) begin
          failures++;
          $display("FAIL drain_write act=%h/%h/%b req=%h/%h/%b",
                   mem_a, mem_wd, mem_opcode, e[69:38], e[37:6], e[5:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s act=%h req=%h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    cpu_we = 1'b0;
    cpu_re = 1'b0;
    repeat (n) tick();
  endtask

  // store alone
  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [5:0] op);
    cpu_we = 1'b1; cpu_re = 1'b0; cpu_a = a; cpu_wd = d; cpu_opcode = op;
    exp_q.push_back({a, d, op});
    @(negedge clk);
    chk("st_stall", 32'(stall), 32'd0);
    tick();
    cpu_we = 1'b0;
  endtask

  // store queued behind a load that owns the port this cycle
  task automatic st_ld(input logic [31:0] a, input logic [31:0] d, input logic [5:0] op,
                       input logic [31:0] exp_rd);
    cpu_we = 1'b1; cpu_re = 1'b1; cpu_a = a; cpu_wd = d; cpu_opcode = op;
    exp_q.push_back({a, d, op});
    @(negedge clk);
    chk("st_ld_stall", 32'(stall), 32'd0);
    chk("st_ld_mem_we", 32'(mem_we), 32'd0);
    chk("st_ld_rd", cpu_rd, exp_rd);
    tick();
    cpu_we = 1'b0; cpu_re = 1'b0;
  endtask

  task automatic ld(input logic [31:0] a, input logic [31:0] exp_d, input int exp_stalls);
    int n;
    bit done;
    cpu_we = 1'b0; cpu_re = 1'b1; cpu_a = a; cpu_opcode = OP_LW;
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge clk);
      if (!stall) done = 1'b1;
      else begin
        n++;
        tick();
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL ld_timeout act=stalled req=released addr=%h", a);
    end else begin
      chk("ld_data", cpu_rd, exp_d);
      chk("ld_stall_cycles", 32'(n), 32'(exp_stalls));
    end
    tick();
    cpu_re = 1'b0;
  endtask

  initial begin
    // reset with a store held on the inputs: nothing may be queued or written
    reset_n = 1'b0; cpu_we = 1'b1; cpu_re = 1'b0;
    cpu_opcode = OP_SW; cpu_a = 32'h200; cpu_wd = 32'h55;
    repeat (2) begin
      @(negedge clk);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      tick();
    end
    reset_n = 1'b1; cpu_we = 1'b0; cpu_a = 32'h44; cpu_opcode = OP_LW;
    @(negedge clk);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mem_we_idle", 32'(mem_we), 32'd0);
    chk("rst_mem_wd", mem_wd, 32'h0);
    chk("rst_mem_a", mem_a, 32'h44);
    chk("rst_mem_opcode", 32'(mem_opcode), 32'(OP_LW));
    tick();

    // store into an empty buffer is written the same cycle
    cpu_we = 1'b1; cpu_a = 32'h10; cpu_wd = 32'hDEADBEEF; cpu_opcode = OP_SW;
    exp_q.push_back({32'h10, 32'hDEADBEEF, OP_SW});
    @(negedge clk);
    chk("sd_mem_we", 32'(mem_we), 32'd1);
    chk("sd_mem_a", mem_a, 32'h10);
    chk("sd_mem_wd", mem_wd, 32'hDEADBEEF);
    chk("sd_mem_opcode", 32'(mem_opcode), 32'(OP_SW));
    tick();
    cpu_we = 1'b0;
    @(negedge clk);
    chk("sd_empty_after", 32'(empty), 32'd1);
    tick();
    ld(32'h10, 32'hDEADBEEF, 0);

    // load hit stall
    st_ld(32'h20, 32'h11223344, OP_SW, 32'h0);
    ld(32'h24, 32'h0, 0);
    ld(32'h20, 32'h11223344, 1);

    // byte ordering through the queue
    st_ld(32'h30, 32'h0, OP_SW, 32'h0);
    st(32'h31, 32'hAB, OP_SB);
    st(32'h33, 32'hCD, OP_SB);
    idle(2);
    ld(32'h30, 32'h00AB00CD, 0);

    // full boundary: fifth store lands in the slot freed by the forced drain
    st_ld(32'h100, 32'hA0, OP_SW, 32'h0);
    st_ld(32'h104, 32'hA1, OP_SW, 32'h0);
    st_ld(32'h108, 32'hA2, OP_SW, 32'h0);
    st_ld(32'h10C, 32'hA3, OP_SW, 32'h0);
    cpu_we = 1'b1; cpu_a = 32'h110; cpu_wd = 32'hA4; cpu_opcode = OP_SW;
    exp_q.push_back({32'h110, 32'hA4, OP_SW});
    @(negedge clk);
    chk("full_before_5th", 32'(full), 32'd1);
    chk("full_5th_stall", 32'(stall), 32'd0);
    chk("full_5th_drain_a", mem_a, 32'h100);
    tick();
    cpu_we = 1'b0;
    @(negedge clk);
    chk("full_after_5th", 32'(full), 32'd1);
    idle(4);
    @(negedge clk);
    chk("full_drained_empty", 32'(empty), 32'd1);
    tick();
    ld(32'h110, 32'hA4, 0);

    // load while full: one drain, then the load proceeds
    st_ld(32'h60, 32'hB0, OP_SW, 32'h0);
    st_ld(32'h64, 32'hB1, OP_SW, 32'h0);
    st_ld(32'h68, 32'hB2, OP_SW, 32'h0);
    st_ld(32'h6C, 32'hB3, OP_SW, 32'h0);
    ld(32'h80, 32'h0, 1);
    idle(4);

    // reset mid-operation discards queued stores
    st_ld(32'h50, 32'h1111, OP_SW, 32'h0);
    st_ld(32'h54, 32'h2222, OP_SW, 32'h0);
    st_ld(32'h58, 32'h3333, OP_SW, 32'h0);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_mem_we", 32'(mem_we), 32'd0);
    tick();
    reset_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_mem_we_after", 32'(mem_we), 32'd0);
    idle(3);
    ld(32'h50, 32'h0, 0);
    ld(32'h54, 32'h0, 0);
    ld(32'h58, 32'h0, 0);

    idle(2);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
